// File: rtl/tinycpu_loader.sv
// Boot/run controller for tinycpu: loads a framed, checksummed program image
// into the 256x12 instruction memory and releases the CPU only on a good image.
module tinycpu_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        cpu_resetn,
   input  logic [7:0]  insn_addr,
   output logic [11:0] insn_opcode,
   output logic        loaded,
   output logic        error,
   output logic        busy
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 12;
   localparam int unsigned RW = 9;
   localparam int unsigned CW = 16;
   localparam int unsigned DEPTH = 256;

   localparam logic [7:0] START_BYTE = 8'hA5;
   localparam logic [7:0] HALT_BYTE  = 8'h5A;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT,
      S_LO,
      S_HI,
      S_SUM,
      S_RUN,
      S_ERR
   } state_t;

   state_t        state;
   logic [AW-1:0] wr_addr;
   logic [7:0]    sum;
   logic [7:0]    lo;
   logic [RW-1:0] remaining;
   logic [CW-1:0] idle_cnt;
   logic [DW-1:0] mem [DEPTH];

   logic accept;
   logic in_frame;
   logic wr_en;

   assign in_ready = resetn;
   assign accept   = in_valid && in_ready;
   assign in_frame = (state == S_CNT) || (state == S_LO) ||
                     (state == S_HI)  || (state == S_SUM);
   assign wr_en    = accept && (state == S_HI);

   // Instruction memory write port; deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= {in_data[3:0], lo};
      end
   end

   // Frame parser, timeout, CPU reset control and synchronous instruction read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         wr_addr     <= '0;
         sum         <= '0;
         lo          <= '0;
         remaining   <= '0;
         idle_cnt    <= '0;
         cpu_resetn  <= 1'b0;
         insn_opcode <= '0;
         loaded      <= 1'b0;
         error       <= 1'b0;
         busy        <= 1'b0;
      end else begin
         insn_opcode <= mem[insn_addr];
         if (in_frame && !accept) begin
            if (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               state    <= S_ERR;
               error    <= 1'b1;
               busy     <= 1'b0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + CW'(1);
            end
         end else if (accept) begin
            idle_cnt <= '0;
            case (state)
               S_IDLE, S_ERR: begin
                  if (in_data == START_BYTE) begin
                     state   <= S_CNT;
                     loaded  <= 1'b0;
                     error   <= 1'b0;
                     busy    <= 1'b1;
                     wr_addr <= '0;
                     sum     <= '0;
                  end
               end
               S_CNT: begin
                  remaining <= (in_data == 8'd0) ? RW'(256) : {1'b0, in_data};
                  sum       <= sum + in_data;
                  state     <= S_LO;
               end
               S_LO: begin
                  lo    <= in_data;
                  sum   <= sum + in_data;
                  state <= S_HI;
               end
               S_HI: begin
                  sum       <= sum + in_data;
                  wr_addr   <= wr_addr + AW'(1);
                  remaining <= remaining - RW'(1);
                  state     <= (remaining == RW'(1)) ? S_SUM : S_LO;
               end
               S_SUM: begin
                  busy <= 1'b0;
                  if (in_data == sum) begin
                     state      <= S_RUN;
                     loaded     <= 1'b1;
                     cpu_resetn <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (in_data == HALT_BYTE) begin
                     state      <= S_IDLE;
                     cpu_resetn <= 1'b0;
                  end
               end
               default: begin
                  state      <= S_IDLE;
                  cpu_resetn <= 1'b0;
                  busy       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tinycpu_loader.sv
// Self-checking bench for tinycpu_loader: byte/flag vector table, directed
// corner sequences and randomized frames against a frame-level reference model.
module tb_tinycpu_loader;

   localparam int unsigned T = 8;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        cpu_resetn;
   logic [7:0]  insn_addr;
   logic [11:0] insn_opcode;
   logic        loaded;
   logic        error;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   tinycpu_loader #(.TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .cpu_resetn  (cpu_resetn),
      .insn_addr   (insn_addr),
      .insn_opcode (insn_opcode),
      .loaded      (loaded),
      .error       (error),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // {busy, loaded, error, cpu_resetn}
   function automatic logic [3:0] flags_now();
      return {busy, loaded, error, cpu_resetn};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic read_mem(input logic [7:0] a, output logic [11:0] d);
      @(negedge clk);
      insn_addr = a;
      @(posedge clk);
      #1;
      d = insn_opcode;
   endtask

   typedef struct {
      logic [7:0] data;
      logic [3:0] exp;
   } vec_t;

   vec_t        tbl[21];
   logic [11:0] rd;
   logic [11:0] mmem[256];
   logic [7:0]  q[$];
   logic [11:0] words[8];
   logic [7:0]  s;
   logic [7:0]  lo;
   logic [7:0]  hi;
   logic [7:0]  jb;
   logic [3:0]  mflags;
   bit          mrun;

   initial begin
      tbl[0]  = '{8'h22, 4'b0000};
      tbl[1]  = '{8'hA5, 4'b1000};
      tbl[2]  = '{8'h02, 4'b1000};
      tbl[3]  = '{8'h34, 4'b1000};
      tbl[4]  = '{8'h08, 4'b1000};
      tbl[5]  = '{8'h12, 4'b1000};
      tbl[6]  = '{8'h01, 4'b1000};
      tbl[7]  = '{8'h51, 4'b0101};
      tbl[8]  = '{8'hA5, 4'b0101};
      tbl[9]  = '{8'h5A, 4'b0100};
      tbl[10] = '{8'hA5, 4'b1000};
      tbl[11] = '{8'h01, 4'b1000};
      tbl[12] = '{8'hFF, 4'b1000};
      tbl[13] = '{8'h0F, 4'b1000};
      tbl[14] = '{8'h00, 4'b0010};
      tbl[15] = '{8'h22, 4'b0010};
      tbl[16] = '{8'hA5, 4'b1000};
      tbl[17] = '{8'h01, 4'b1000};
      tbl[18] = '{8'h23, 4'b1000};
      tbl[19] = '{8'h0A, 4'b1000};
      tbl[20] = '{8'h2E, 4'b0101};

      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      insn_addr = 8'h00;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flags", 16'(flags_now()), 16'h0);
      chk("reset_in_ready", 16'(in_ready), 16'h0);
      chk("reset_opcode", 16'(insn_opcode), 16'h0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("in_ready_after_reset", 16'(in_ready), 16'h1);

      // vector table: one byte per entry, flags checked after acceptance
      for (int i = 0; i < 21; i++) begin
         send_byte(tbl[i].data);
         chk($sformatf("tbl[%0d]", i), 16'(flags_now()), 16'(tbl[i].exp));
      end
      read_mem(8'd0, rd);
      chk("tbl_mem0", 16'(rd), 16'hA23);
      send_byte(8'h5A);

      // good load with opcode visible before release
      insn_addr = 8'd0;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h34); send_byte(8'h08);
      idle(1);
      chk("good_opcode_in_reset", 16'(insn_opcode), 16'h834);
      chk("good_cpu_held", 16'(cpu_resetn), 16'h0);
      send_byte(8'h12); send_byte(8'h01); send_byte(8'h51);
      chk("good_release", 16'(flags_now()), 16'b0101);
      read_mem(8'd1, rd);
      chk("good_mem1", 16'(rd), 16'h112);
      send_byte(8'h5A);
      chk("halt_flags", 16'(flags_now()), 16'b0100);

      // bad checksum then recovery
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h00);
      chk("bad_flags", 16'(flags_now()), 16'b0010);
      read_mem(8'd0, rd);
      chk("bad_mem0", 16'(rd), 16'hFFF);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34); send_byte(8'h08); send_byte(8'h3D);
      chk("recover_flags", 16'(flags_now()), 16'b0101);
      read_mem(8'd0, rd);
      chk("recover_mem0", 16'(rd), 16'h834);
      send_byte(8'h5A);

      // COUNT=0 means 256 words, with a 3-cycle stall mid-stream
      send_byte(8'hA5);
      send_byte(8'h00);
      s = 8'h00;
      for (int i = 0; i < 256; i++) begin
         lo = 8'(i);
         hi = {4'($urandom_range(0, 15)), 4'(i)};
         s  = s + lo + hi;
         send_byte(lo);
         if (i == 100) idle(3);
         send_byte(hi);
      end
      chk("c256_busy", 16'(busy), 16'h1);
      send_byte(s);
      chk("c256_release", 16'(flags_now()), 16'b0101);
      read_mem(8'd255, rd);
      chk("c256_mem255", 16'(rd), 16'hFFF);
      read_mem(8'd0, rd);
      chk("c256_mem0", 16'(rd), 16'h000);
      read_mem(8'h5A, rd);
      chk("c256_mem5a", 16'(rd), 16'hA5A);
      send_byte(8'h5A);

      // timeout boundary, stray byte, restart
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      idle(T - 1);
      chk("timeout_not_yet", 16'(flags_now()), 16'b1000);
      idle(1);
      chk("timeout_hit", 16'(flags_now()), 16'b0010);
      send_byte(8'h22);
      chk("err_drop", 16'(flags_now()), 16'b0010);
      send_byte(8'hA5);
      chk("err_restart", 16'(flags_now()), 16'b1000);
      send_byte(8'h01); send_byte(8'h44);

      // async reset while waiting for HI
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rst_mid_hi_flags", 16'(flags_now()), 16'b0000);
      chk("rst_mid_hi_ready", 16'(in_ready), 16'h0);
      @(negedge clk);
      resetn = 1'b1;

      // async reset in RUN drops cpu_resetn immediately
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      chk("pre_rst_run", 16'(flags_now()), 16'b0101);
      #3;
      resetn = 1'b0;
      #1;
      chk("rst_in_run_flags", 16'(flags_now()), 16'b0000);
      chk("rst_in_run_opcode", 16'(insn_opcode), 16'h0);
      @(negedge clk);
      resetn = 1'b1;

      // randomized frames against a frame-level model
      mrun   = 1'b0;
      mflags = 4'b0000;
      for (int it = 0; it < 30; it++) begin
         int n;
         int kind;
         int k;
         int jw;
         n = int'($urandom_range(0, 2));
         for (int j = 0; j < n; j++) begin
            jb = 8'($urandom);
            if (mrun && jb == 8'h5A) jb = 8'h00;
            if (!mrun && jb == 8'hA5) jb = 8'h00;
            send_byte(jb);
         end
         chk($sformatf("rnd%0d_junk", it), 16'(flags_now()), 16'(mflags));
         if (mrun) begin
            send_byte(8'h5A);
            mflags = 4'b0100;
            chk($sformatf("rnd%0d_halt", it), 16'(flags_now()), 16'(mflags));
         end

         n = int'($urandom_range(1, 8));
         kind = int'($urandom_range(0, 3));
         q.delete();
         q.push_back(8'hA5);
         q.push_back(8'(n));
         s = 8'(n);
         for (int j = 0; j < n; j++) begin
            words[j] = 12'($urandom);
            lo = words[j][7:0];
            hi = {4'($urandom_range(0, 15)), words[j][11:8]};
            q.push_back(lo);
            q.push_back(hi);
            s = s + lo + hi;
         end
         if (kind == 0 || kind == 1) q.push_back(s);
         else if (kind == 2) q.push_back(s ^ 8'($urandom_range(1, 255)));

         k = (kind == 3) ? int'($urandom_range(1, q.size())) : q.size();
         for (int j = 0; j < k; j++) begin
            if (j > 0) idle(int'($urandom_range(0, T - 1)));
            send_byte(q[j]);
            if (j == 0) chk($sformatf("rnd%0d_busy", it), 16'(busy), 16'h1);
         end

         if (kind == 3) begin
            idle(T - 1);
            chk($sformatf("rnd%0d_pre_to", it), 16'(flags_now()), 16'b1000);
            idle(1);
            jw = (k >= 2) ? (k - 2) / 2 : 0;
            mflags = 4'b0010;
            mrun = 1'b0;
         end else begin
            jw = n;
            mrun = (kind != 2);
            mflags = mrun ? 4'b0101 : 4'b0010;
         end
         chk($sformatf("rnd%0d_end", it), 16'(flags_now()), 16'(mflags));
         for (int j = 0; j < jw; j++) mmem[j] = words[j];
         for (int j = 0; j < jw; j++) begin
            read_mem(8'(j), rd);
            chk($sformatf("rnd%0d_mem%0d", it, j), 16'(rd), 16'(mmem[j]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
